aes_inv_top: RTL
================

AES_INV_TOP -- requirements
Module: aes_inv_top

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports AES_clk and AES_rst_n.
REQ-002 Parameter NR, default 10, SHALL set the number of AES-128 rounds; only 10 is supported.
REQ-003 Port AES_clk, input, 1 bit: clock, all state on the rising edge.
REQ-004 Port AES_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port AES_en, input, 1 bit: start request, level input, edge-qualified internally.
REQ-006 Port AES_data_in, input, 128 bits: ciphertext; bit 127 is byte 0 (FIPS-197 order).
REQ-007 Port AES_key_in, input, 128 bits: the final (round-10) round key of the AES-128 schedule.
REQ-008 Port AES_data_out, output, 128 bits: plaintext result.
REQ-009 Port AES_data_out_valid, output, 1 bit: one-cycle pulse marking a new AES_data_out.

Function
REQ-010 A start SHALL be accepted at a rising edge where AES_en=1, the registered AES_en of the previous cycle was 0, and the FSM is in IDLE.
REQ-011 On acceptance, the block SHALL capture state = AES_data_in XOR AES_key_in and key = AES_key_in, set round counter = 1, and enter RUN.
REQ-012 In RUN, each cycle SHALL perform one inverse round:
- derive the previous round key by inverse key expansion: w[i] ^= w[i-1] for i = 3..1, then w[0] ^= SubWord(RotWord(w[3])) ^ Rcon.
- Rcon SHALL be descending 36,1b,80,40,20,10,08,04,02,01.
- apply InvShiftRows, then InvSubBytes, then AddRoundKey with the derived key.
- apply InvMixColumns on rounds 1..9 only.
REQ-013 Round 10 SHALL omit InvMixColumns, load AES_data_out, pulse AES_data_out_valid for exactly one cycle, and return to IDLE.
REQ-014 Latency SHALL be 10 cycles: valid is high on the 10th rising edge after the accepting edge.
REQ-015 Throughput SHALL be one block per 11 cycles at minimum, because a new start needs an AES_en low-to-high transition while in IDLE.
REQ-016 Holding AES_en high SHALL NOT retrigger; a rising AES_en during RUN SHALL be ignored and not queued.
REQ-017 AES_data_in and AES_key_in SHALL be sampled only at acceptance; changes during RUN SHALL have no effect.
REQ-018 AES_data_out SHALL hold its value until the next completion; AES_data_out_valid SHALL be 0 at all other times.
REQ-019 FSM states SHALL be IDLE and RUN only; the round counter is 4 bits and wraps only via reset to 0 in IDLE.
REQ-020 An illegal counter value (0 or above 10) in RUN SHALL force IDLE without asserting valid.

Reset
REQ-021 AES_rst_n low SHALL immediately clear:
- FSM to IDLE
- round counter, state, key, and registered AES_en to 0
- AES_data_out to 128'h0
- AES_data_out_valid to 0
REQ-022 Reset asserted mid-operation SHALL abort the block with no valid pulse.
REQ-023 After reset release, an AES_en already high SHALL count as a rising edge at the first active clock.

Structure
REQ-024 A shared package aes_pkg SHALL hold:
- the forward and inverse S-box tables
- the Rcon table
- the FSM state enum
- the GF(2^8) xtime and multiply functions used by InvMixColumns
REQ-025 Sub-module aes_inv_key_step SHALL be combinational and implement one inverse key-expansion step (key_in, rcon -> key_out); all sequential logic SHALL remain in aes_inv_top.

Verification
REQ-026 FIPS-197 C.1 SHALL pass: key_in 13111d7fe3944a17f307a78b4d2b30c5, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> AES_data_out 00112233445566778899aabbccddeeff, valid on the 10th edge after acceptance.
REQ-027 FIPS-197 App. B SHALL pass: key_in d014f9a8c9ee2589e13f0cc8b6630ca6, data_in 3925841d02dc09fbdc118597196a0b32 -> AES_data_out 3243f6a8885a308d313198a2e0370734.
REQ-028 Level hold and input changes SHALL be ignored: AES_en held high 51 cycles with AES_data_in changed every cycle during RUN -> exactly one valid pulse, result equal to the REQ-026 plaintext.
REQ-029 Back-to-back starts SHALL work: the REQ-026 vector, AES_en low 1 cycle after valid, then the REQ-027 vector -> two valid pulses with correct outputs, 11 cycles apart minimum.
REQ-030 Mid-operation reset SHALL abort: AES_rst_n low at round 5 -> AES_data_out = 0, no valid pulse, IDLE; a subsequent REQ-026 vector -> correct result.
REQ-031 A round-trip test SHALL pass: encrypt random vectors with AES_top, feed the ciphertext and the matching round-10 key -> original plaintext for 1000 vectors.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, inverse Rcon, FSM states, GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned RND_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entry for input byte b is stored at index 255-b (row 0 sits in the MSBs).
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[~b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[~b];
    endfunction

    // Rcon walked backwards: inverse round 1 undoes the forward round-10 step.
    function automatic logic [7:0] rcon_inv(input logic [RND_W-1:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h36;
            4'd2:    rc = 8'h1b;
            4'd3:    rc = 8'h80;
            4'd4:    rc = 8'h40;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h10;
            4'd7:    rc = 8'h08;
            4'd8:    rc = 8'h04;
            4'd9:    rc = 8'h02;
            4'd10:   rc = 8'h01;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse AES-128 key-expansion step: round key k -> round key k-1.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] key_i,
    input  logic [7:0]         rcon_i,
    output logic [BLOCK_W-1:0] key_c_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p3, g_word;

    assign {w0, w1, w2, w3} = key_i;

    // Undo the chained word XORs, then the SubWord(RotWord()) ^ Rcon term on word 0.
    assign p3     = w3 ^ w2;
    assign g_word = {sbox(p3[23:16]) ^ rcon_i, sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
    assign key_c_o = {w0 ^ g_word, w1 ^ w0, w2 ^ w1, p3};

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: one inverse round per clock, key schedule run backwards.
module aes_inv_top
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic               AES_clk,
    input  logic               AES_rst_n,
    input  logic               AES_en,
    input  logic [BLOCK_W-1:0] AES_data_in,
    input  logic [BLOCK_W-1:0] AES_key_in,
    output logic [BLOCK_W-1:0] AES_data_out,
    output logic               AES_data_out_valid
);

    state_e             fsm_q, fsm_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [BLOCK_W-1:0] st_q, st_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               en_q;
    logic               start_c;
    logic [BLOCK_W-1:0] key_prev_c;

    // FIPS byte i of the state lives at index 15-i.
    logic [15:0][7:0] cur_b, isr_b, isb_b, ark_b, imc_b;

    aes_inv_key_step u_key_step (
        .key_i   (key_q),
        .rcon_i  (rcon_inv(rnd_q)),
        .key_c_o (key_prev_c)
    );

    assign cur_b = st_q;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates right by r columns.
            assign isr_b[15-(4*c+r)] = cur_b[15-(4*((c-r+4)%4)+r)];
            assign isb_b[15-(4*c+r)] = inv_sbox(isr_b[15-(4*c+r)]);
        end
        assign imc_b[15-4*c] = gf_mul(8'h0e, ark_b[15-4*c]) ^ gf_mul(8'h0b, ark_b[14-4*c])
                             ^ gf_mul(8'h0d, ark_b[13-4*c]) ^ gf_mul(8'h09, ark_b[12-4*c]);
        assign imc_b[14-4*c] = gf_mul(8'h09, ark_b[15-4*c]) ^ gf_mul(8'h0e, ark_b[14-4*c])
                             ^ gf_mul(8'h0b, ark_b[13-4*c]) ^ gf_mul(8'h0d, ark_b[12-4*c]);
        assign imc_b[13-4*c] = gf_mul(8'h0d, ark_b[15-4*c]) ^ gf_mul(8'h09, ark_b[14-4*c])
                             ^ gf_mul(8'h0e, ark_b[13-4*c]) ^ gf_mul(8'h0b, ark_b[12-4*c]);
        assign imc_b[12-4*c] = gf_mul(8'h0b, ark_b[15-4*c]) ^ gf_mul(8'h0d, ark_b[14-4*c])
                             ^ gf_mul(8'h09, ark_b[13-4*c]) ^ gf_mul(8'h0e, ark_b[12-4*c]);
    end

    assign ark_b   = isb_b ^ key_prev_c;
    assign start_c = AES_en && !en_q && (fsm_q == IDLE);

    // Next-state logic: accept on an en rising edge in IDLE, one round per cycle in RUN.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        key_d   = key_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                rnd_d = '0;
                if (start_c) begin
                    st_d  = AES_data_in ^ AES_key_in;
                    key_d = AES_key_in;
                    rnd_d = 4'd1;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                if (rnd_q == '0 || rnd_q > RND_W'(NR)) begin
                    rnd_d = '0;
                    fsm_d = IDLE;
                end else if (rnd_q == RND_W'(NR)) begin
                    dout_d  = ark_b;
                    valid_d = 1'b1;
                    rnd_d   = '0;
                    fsm_d   = IDLE;
                end else begin
                    st_d  = imc_b;
                    key_d = key_prev_c;
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            en_q    <= AES_en;
        end
    end

    assign AES_data_out       = dout_q;
    assign AES_data_out_valid = valid_q;

endmodule
